// File: rtl/cdb_arb_pkg.sv
// Shared definitions for the CDB arbiter: FSM state encoding, default parameters
// and the circular index increment used for the round-robin pointer.
package cdb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ         = 4;
    localparam int DEF_PTR_W           = 2;
    localparam int DEF_HOLD_CYCLES     = 1;
    localparam int DEF_RELEASE_TIMEOUT = 8;
    localparam int DEF_CNT_W           = 16;

    // Next index after v in a ring of n entries (n-1 wraps to 0).
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational circular priority encoder: returns the first set request at or
// after ptr, wrapping past NUM_REQ-1 back to 0.
module cdb_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               any,
    output logic [PTR_W-1:0]   idx
);

    int best;
    int off;

    // Each request's distance from ptr around the ring; smallest distance wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        best = NUM_REQ;
        off  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            off = i - int'(ptr);
            if (off < 0) begin
                off = off + NUM_REQ;
            end
            if (req[i] && (off < best)) begin
                best = off;
                idx  = PTR_W'(i);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one-hot xmit grant held for HOLD_CYCLES, then waits for
// the owner to drop rts (bounded by RELEASE_TIMEOUT). Optional per-unit grant
// statistics are compiled in with the CDB_ARB_STATS_EN macro.
module cdb_arbiter
    import cdb_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int PTR_W           = DEF_PTR_W,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int RELEASE_TIMEOUT = DEF_RELEASE_TIMEOUT,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
`ifdef CDB_ARB_STATS_EN
    input  logic                     stats_clear,
    output logic [NUM_REQ*CNT_W-1:0] grant_count,
`endif
    input  logic [NUM_REQ-1:0]       rts,
    output logic [NUM_REQ-1:0]       xmit,
    output logic                     grant_valid,
    output logic [PTR_W-1:0]         grant_id,
    output logic                     busy,
    output logic                     error
);

    // One timer serves both the hold window and the release timeout.
    localparam int TMR_MAX = (HOLD_CYCLES > RELEASE_TIMEOUT) ? HOLD_CYCLES : RELEASE_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    arb_state_t           state_reg, state_next;
    logic [NUM_REQ-1:0]   xmit_reg, xmit_next;
    logic [PTR_W-1:0]     grant_id_reg, grant_id_next;
    logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [TMR_W-1:0]     tmr_reg, tmr_next;
    logic                 grant_valid_reg;
    logic                 busy_reg;
    logic                 error_reg, error_next;

    logic                 pick_any;
    logic [PTR_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [NUM_REQ-1:0]   owner_sel;
    logic                 owner_rts;
    logic [PTR_W-1:0]     ptr_after_owner;

    cdb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req (rts),
        .ptr (rr_ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_decode
            assign pick_onehot[gi] = (pick_idx == PTR_W'(gi));
            assign owner_sel[gi]   = rts[gi] & (grant_id_reg == PTR_W'(gi));
        end
    endgenerate

    assign owner_rts       = |owner_sel;
    assign ptr_after_owner = PTR_W'(wrap_inc(int'(grant_id_reg), NUM_REQ));

    always_comb begin
        state_next    = state_reg;
        xmit_next     = xmit_reg;
        grant_id_next = grant_id_reg;
        rr_ptr_next   = rr_ptr_reg;
        tmr_next      = tmr_reg;
        error_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                xmit_next = '0;
                if (pick_any) begin
                    state_next    = ST_GRANT;
                    xmit_next     = pick_onehot;
                    grant_id_next = pick_idx;
                    tmr_next      = TMR_W'(HOLD_CYCLES - 1);
                end
            end
            ST_GRANT: begin
                // Window expired or owner withdrew: free the bus on this edge.
                if (!owner_rts || (tmr_reg == '0)) begin
                    state_next = ST_RELEASE;
                    xmit_next  = '0;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg - TMR_W'(1);
                end
            end
            ST_RELEASE: begin
                xmit_next = '0;
                if (!owner_rts) begin
                    state_next  = ST_IDLE;
                    rr_ptr_next = ptr_after_owner;
                end else if (tmr_reg == TMR_W'(RELEASE_TIMEOUT - 1)) begin
                    state_next  = ST_IDLE;
                    rr_ptr_next = ptr_after_owner;
                    error_next  = 1'b1;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                xmit_next  = '0;
                tmr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            xmit_reg        <= '0;
            grant_id_reg    <= '0;
            rr_ptr_reg      <= '0;
            tmr_reg         <= '0;
            grant_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            xmit_reg        <= xmit_next;
            grant_id_reg    <= grant_id_next;
            rr_ptr_reg      <= rr_ptr_next;
            tmr_reg         <= tmr_next;
            grant_valid_reg <= |xmit_next;
            busy_reg        <= (state_next != ST_IDLE);
            error_reg       <= error_next;
        end
    end

    assign xmit        = xmit_reg;
    assign grant_valid = grant_valid_reg;
    assign grant_id    = grant_id_reg;
    assign busy        = busy_reg;
    assign error       = error_reg;

`ifdef CDB_ARB_STATS_EN
    logic grant_evt;
    assign grant_evt = (state_reg == ST_IDLE) && pick_any;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [CNT_W-1:0] cnt_reg;

            // Clear has priority over a same-cycle grant; counts saturate.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else if (stats_clear) begin
                    cnt_reg <= '0;
                end else if (grant_evt && (pick_idx == PTR_W'(gi)) && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign grant_count[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected grant owners come from a reference
// round-robin model and are queued as requests are driven, then checked per grant.
module tb_cdb_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 3;
    localparam int TMO  = 8;
    localparam int CW   = 2;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] rts     = '0;
    logic [N-1:0] xmit;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         busy;
    logic         error;
`ifdef CDB_ARB_STATS_EN
    logic            stats_clear = 1'b0;
    logic [N*CW-1:0] grant_count;
`endif

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int model_ptr = 0;
    int exp_q[$];

    cdb_arbiter #(
        .NUM_REQ         (N),
        .PTR_W           (2),
        .HOLD_CYCLES     (HOLD),
        .RELEASE_TIMEOUT (TMO),
        .CNT_W           (CW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
`ifdef CDB_ARB_STATS_EN
        .stats_clear (stats_clear),
        .grant_count (grant_count),
`endif
        .rts         (rts),
        .xmit        (xmit),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .busy        (busy),
        .error       (error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        tick();
        tick();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_ptr = 0;
        exp_q.delete();
    endtask

    task automatic push_expected(output int e);
        e = model_pick(rts, model_ptr);
        exp_q.push_back(e);
        model_ptr = (e + 1) % N;
    endtask

    // Waits for xmit to go non-zero; nwait counts idle samples seen first.
    task automatic wait_grant(output int idx, output int nwait);
        bit got;
        got   = 1'b0;
        idx   = -1;
        nwait = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if (xmit != '0) begin
                got = 1'b1;
                for (int i = 0; i < N; i++) if (xmit[i]) idx = i;
            end else begin
                nwait++;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: xmit %b after 40 cycles, required a grant", xmit);
        end else if (!$onehot(xmit) || grant_valid !== 1'b1 || grant_id !== 2'(idx) || busy !== 1'b1) begin
            errors++;
            $display("FAIL grant_outputs: xmit %b valid %b id %0d busy %b, required one-hot valid=1 id=%0d busy=1",
                     xmit, grant_valid, grant_id, busy, idx);
        end
    endtask

    task automatic check_pop(input int idx);
        int e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : -1;
        checks++;
        if (idx != e) begin
            errors++;
            $display("FAIL grant_owner: got unit %0d, required unit %0d", idx, e);
        end
        $display("grant unit %0d at cycle %0d", idx, cyc);
    endtask

    // Counts samples with xmit high (the grant sample included) until it falls.
    task automatic wait_fall(output int high);
        bit fell;
        fell = 1'b0;
        high = 1;
        for (int n = 0; n < 40 && !fell; n++) begin
            tick();
            if (xmit == '0) fell = 1'b1;
            else high++;
        end
        checks++;
        if (!fell || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL xmit_fall: xmit %b valid %b, required 0 and 0", xmit, grant_valid);
        end
    endtask

    // Serves n grants; each owner drops rts one cycle after its xmit falls.
    task automatic serve(input int n);
        int e, idx, nwait, high;
        for (int g = 0; g < n; g++) begin
            push_expected(e);
            wait_grant(idx, nwait);
            if (idx < 0) return;
            check_pop(idx);
            if (g > 0) begin
                checks++;
                if (nwait + 2 != 3) begin
                    errors++;
                    $display("FAIL idle_gap: %0d idle cycles between grants, required 3", nwait + 2);
                end
            end
            wait_fall(high);
            checks++;
            if (high != HOLD) begin
                errors++;
                $display("FAIL hold_len: xmit high %0d cycles, required %0d", high, HOLD);
            end
            tick();
            rts[idx] = 1'b0;
        end
    endtask

    task automatic test_reset();
        int e, waited;
        reset_n = 1'b0;
        rts     = 4'b1111;
        tick(); tick(); tick();
        checks++;
        if (xmit !== '0 || busy !== 1'b0 || grant_valid !== 1'b0 || grant_id !== 2'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: xmit %b busy %b valid %b id %0d err %b, required all zero",
                     xmit, busy, grant_valid, grant_id, error);
        end
        reset_n = 1'b1;
        push_expected(e);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (xmit !== 4'(1 << e)) begin
            errors++;
            $display("FAIL reset_first_grant: xmit %b, required %b", xmit, 4'(1 << e));
        end
        $display("grant unit %0d at cycle %0d", e, cyc);
        rts    = '0;
        waited = 0;
        while (busy !== 1'b0 && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain: busy %b, required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        settle();
        pulse_reset();
        rts = 4'b1111;
        serve(4);
        settle();
        rts[0] = 1'b1;
        serve(1);
    endtask

    task automatic test_wrap_skip();
        settle();
        rts = 4'b0100;
        serve(1);
        settle();
        rts = 4'b0101;
        serve(2);
        settle();
        rts = 4'b1010;
        serve(2);
    endtask

    task automatic test_timeout();
        int e, idx, nwait, high, n;
        bit seen;
        settle();
        rts = 4'b0010;
        push_expected(e);
        wait_grant(idx, nwait);
        check_pop(idx);
        wait_fall(high);
        rts[2] = 1'b1;
        n      = 0;
        seen   = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            n++;
            if (error === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != TMO) begin
            errors++;
            $display("FAIL timeout_delay: error after %0d cycles (seen %0d), required %0d", n, seen, TMO);
        end
        model_ptr = 2;
        rts[1]    = 1'b0;
        push_expected(e);
        wait_grant(idx, nwait);
        check_pop(idx);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: error %b one cycle later, required 0", error);
        end
        wait_fall(high);
        tick();
        rts[2] = 1'b0;
    endtask

    task automatic test_withdraw_reset();
        int e, idx, nwait;
        settle();
        rts = 4'b0100;
        push_expected(e);
        wait_grant(idx, nwait);
        check_pop(idx);
        tick();
        rts[2] = 1'b0;
        tick();
        checks++;
        if (xmit !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL withdraw_drop: xmit %b busy %b, required 0000 busy=1", xmit, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_idle: busy %b, required 0", busy);
        end
        rts = 4'b1000;
        push_expected(e);
        wait_grant(idx, nwait);
        check_pop(idx);
        reset_n = 1'b0;
        #1;
        checks++;
        if (xmit !== '0 || busy !== 1'b0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: xmit %b busy %b valid %b, required all zero mid-cycle",
                     xmit, busy, grant_valid);
        end
        rts = '0;
        tick();
        reset_n   = 1'b1;
        model_ptr = 0;
        tick(); tick();
        checks++;
        if (xmit !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_resume: xmit %b busy %b, required 0 and 0", xmit, busy);
        end
        rts = 4'b1001;
        serve(2);
    endtask

`ifdef CDB_ARB_STATS_EN
    task automatic test_stats();
        int e, idx, nwait, high, want;
        settle();
        pulse_reset();
        checks++;
        if (grant_count !== '0) begin
            errors++;
            $display("FAIL stats_reset: grant_count %h, required 0", grant_count);
        end
        for (int k = 1; k <= 5; k++) begin
            settle();
            rts[0] = 1'b1;
            serve(1);
            want = (k > 3) ? 3 : k;
            checks++;
            if (grant_count[CW-1:0] !== CW'(want) || grant_count[N*CW-1:CW] !== '0) begin
                errors++;
                $display("FAIL stats_count: grant_count %b after %0d grants, required unit0=%0d others 0",
                         grant_count, k, want);
            end
        end
        settle();
        rts[0]      = 1'b1;
        stats_clear = 1'b1;
        push_expected(e);
        wait_grant(idx, nwait);
        stats_clear = 1'b0;
        check_pop(idx);
        checks++;
        if (grant_count !== '0) begin
            errors++;
            $display("FAIL stats_clear: grant_count %b, required 0 (clear beats increment)", grant_count);
        end
        wait_fall(high);
        tick();
        rts[0] = 1'b0;
        settle();
        checks++;
        if (grant_count !== '0) begin
            errors++;
            $display("FAIL stats_hold: grant_count %b, required 0", grant_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_timeout();
        test_withdraw_reset();
`ifdef CDB_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
